dmem_sized_wait: RTL and testbench

- Parametrised successor to the single-cycle data memory: byte-addressed, little-endian, 32-bit words.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Uses a valid/ready request handshake with a programmable number of wait states, so a multicycle or pipelined core can model slow memory.
- Reports misaligned and out-of-range accesses through an error flag instead of silently corrupting memory.

---
 rtl/dmem_sized_wait.sv | 174 +++++++++++++++++
 tb/tb_dmem_sized_wait.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sized_wait.sv
// Byte-addressed little-endian data memory with sized loads/stores, a
// valid/ready request port, programmable wait states and an error response.
module dmem_sized_wait #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       ReadData,
  output logic              resp_valid,
  output logic              err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              mem_we_d;
  logic [31:0]       mem_wword_d;

  // Memory is not reset; its power-up image is part of the declaration.
  logic [31:0] mem_q [DEPTH] = '{1: 32'h0000_0054, 2: 32'h0000_000B, default: 32'h0};

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             bad;
  logic [31:0]      rword;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  logic [31:0]      load_val;

  // Address decode, error detection, load extraction and store merge.
  always_comb begin
    idx      = addr_q[IDX_W+1:2];
    lane     = addr_q[1:0];
    bad      = (|(addr_q >> (IDX_W + 2)))
             || (size_q == 2'b11)
             || ((size_q == 2'b01) && lane[0])
             || ((size_q == 2'b10) && (lane != 2'b00));
    rword    = mem_q[idx];
    rbyte    = rword[{lane, 3'b000} +: 8];
    rhalf    = lane[1] ? rword[31:16] : rword[15:0];
    load_val = rword;
    mem_wword_d = rword;
    case (size_q)
      2'b00: begin
        load_val = {{24{~uns_q & rbyte[7]}}, rbyte};
        mem_wword_d[{lane, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = {{16{~uns_q & rhalf[15]}}, rhalf};
        if (lane[1]) mem_wword_d[31:16] = wdata_q[15:0];
        else         mem_wword_d[15:0]  = wdata_q[15:0];
      end
      default: begin
        load_val    = rword;
        mem_wword_d = wdata_q;
      end
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    err_d        = err_q;
    ready_d      = ready_q;
    mem_we_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && (memread || memwrite)) begin
          addr_d  = address;
          size_d  = size;
          uns_d   = unsigned_ld;
          wdata_d = writedata;
          rd_d    = memread;
          ready_d = 1'b0;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RESP: begin
        resp_valid_d = 1'b1;
        err_d        = bad;
        if (bad)       rdata_d  = '0;
        else if (rd_q) rdata_d  = load_val;
        else           mem_we_d = 1'b1;
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
    end
  end

  // A reset landing on the access edge abandons the store.
  always_ff @(posedge clk) begin
    if (!reset && mem_we_d) mem_q[idx] <= mem_wword_d;
  end

  assign req_ready  = ready_q;
  assign ReadData   = rdata_q;
  assign resp_valid = resp_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dmem_sized_wait.sv
// Randomised and directed bench for dmem_sized_wait against a byte-array
// reference model of the memory and its load/store/error rules.
module tb_dmem_sized_wait;

  localparam int unsigned DEPTH       = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned WAIT_CYCLES = 2;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              memread;
  logic              memwrite;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writedata;
  logic [31:0]       ReadData;
  logic              resp_valid;
  logic              err;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ref_bytes [4*DEPTH];
  logic [31:0] ref_rdata;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } op_t;

  dmem_sized_wait #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .memread(memread), .memwrite(memwrite), .size(size), .unsigned_ld(unsigned_ld),
    .address(address), .writedata(writedata), .ReadData(ReadData),
    .resp_valid(resp_valid), .err(err)
  );

  always #5 clk = ~clk;

  function automatic op_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd);
    op_t o;
    o.rd = rd; o.wr = wr; o.sz = sz; o.uns = uns; o.a = a; o.wd = wd; o.exp_rd = exp_rd;
    return o;
  endfunction

  task automatic drive_idle();
    req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0; size = 2'b00;
    unsigned_ld = 1'b0; address = '0; writedata = '0;
  endtask

  task automatic drive_req(input op_t o);
    req_valid = 1'b1; memread = o.rd; memwrite = o.wr; size = o.sz;
    unsigned_ld = o.uns; address = o.a; writedata = o.wd;
  endtask

  // Reference: memory is a byte array, responses follow the access rules directly.
  task automatic model(input op_t o, output logic [31:0] e_rd, output logic e_err);
    int n;
    logic [31:0] v;
    n = 1 << o.sz;
    e_err = (o.a >= 32'(4*DEPTH)) || (o.sz == 2'b11) || ((o.a % 32'(n)) != 0);
    if (e_err) begin
      ref_rdata = '0;
    end else if (o.rd) begin
      v = '0;
      for (int i = 0; i < n; i++) v |= 32'(ref_bytes[int'(o.a) + i]) << (8*i);
      if (!o.uns && n < 4 && v[8*n-1]) v |= ~((32'h1 << (8*n)) - 32'h1);
      ref_rdata = v;
    end else begin
      for (int i = 0; i < n; i++) ref_bytes[int'(o.a) + i] = o.wd[8*i +: 8];
    end
    e_rd = ref_rdata;
  endtask

  // Issue one request, return the response and cycles from acceptance to response.
  task automatic do_req(input op_t o, output logic [31:0] got_rd, output logic got_err,
                        output int lat, output int busy_ready);
    int w;
    got_rd = 'x; got_err = 1'bx; lat = -1; busy_ready = 0;
    @(negedge clk);
    drive_req(o);
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
      drive_idle();
      return;
    end
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    lat = 0;
    while (!resp_valid && lat < 50) begin
      if (req_ready) busy_ready++;
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      checks++; failures++;
      $display("FAIL resp_timeout: resp_valid=%0b required 1", resp_valid);
      lat = -1;
      return;
    end
    got_rd = ReadData;
    got_err = err;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_rdata = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b required 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %0b required 0", resp_valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b required 0", err); end
    checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h required 00000000", ReadData); end
  endtask

  task automatic test_timing();
    op_t o;
    logic [31:0] got, e_rd;
    logic ge, e_err;
    int lat, busy;
    o = mk(1, 0, 2'b10, 0, 32'd4, 32'h0, 32'h0000_0054);
    do_req(o, got, ge, lat, busy);
    model(o, e_rd, e_err);
    checks++; if (lat !== int'(WAIT_CYCLES) + 1) begin failures++; $display("FAIL timing_latency: got %0d required %0d", lat, WAIT_CYCLES + 1); end
    checks++; if (busy !== 0) begin failures++; $display("FAIL timing_ready_busy: ready seen %0d times required 0", busy); end
    checks++; if (got !== o.exp_rd || got !== e_rd) begin failures++; $display("FAIL timing_rdata: got %h required %h", got, o.exp_rd); end
    checks++; if (ge !== 1'b0) begin failures++; $display("FAIL timing_err: got %0b required 0", ge); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL timing_ready_back: got %0b required 1", req_ready); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL timing_pulse: got %0b required 0", resp_valid); end
  endtask

  task automatic test_sized();
    op_t ops[$];
    logic [31:0] got, e_rd;
    logic ge, e_err;
    int lat, busy;
    ops.push_back(mk(0, 1, 2'b10, 0, 32'd8,  32'hDEAD_BEEF, 32'hx));
    ops.push_back(mk(1, 0, 2'b00, 0, 32'd11, 32'h0, 32'hFFFF_FFDE));
    ops.push_back(mk(1, 0, 2'b00, 1, 32'd11, 32'h0, 32'h0000_00DE));
    ops.push_back(mk(1, 0, 2'b01, 0, 32'd10, 32'h0, 32'hFFFF_DEAD));
    ops.push_back(mk(1, 0, 2'b01, 1, 32'd10, 32'h0, 32'h0000_DEAD));
    ops.push_back(mk(1, 0, 2'b00, 0, 32'd8,  32'h0, 32'hFFFF_FFEF));
    ops.push_back(mk(0, 1, 2'b00, 0, 32'd9,  32'hAAAA_AA12, 32'hx));
    ops.push_back(mk(0, 1, 2'b01, 0, 32'd8,  32'hBBBB_7777, 32'hx));
    ops.push_back(mk(1, 0, 2'b10, 0, 32'd8,  32'h0, 32'hDEAD_7777));
    foreach (ops[i]) begin
      do_req(ops[i], got, ge, lat, busy);
      model(ops[i], e_rd, e_err);
      if (ops[i].rd) begin
        checks++; if (got !== ops[i].exp_rd) begin failures++; $display("FAIL sized_const[%0d]: got %h required %h", i, got, ops[i].exp_rd); end
      end
      checks++; if (got !== e_rd || ge !== e_err) begin failures++; $display("FAIL sized_model[%0d]: got %h/%0b required %h/%0b", i, got, ge, e_rd, e_err); end
    end
  endtask

  task automatic test_errors();
    op_t ops[$];
    op_t chk;
    logic [31:0] got, e_rd;
    logic ge, e_err;
    int lat, busy;
    ops.push_back(mk(1, 0, 2'b10, 0, 32'd6,   32'h0, 32'h0));
    ops.push_back(mk(0, 1, 2'b01, 0, 32'd3,   32'h5555_5555, 32'h0));
    ops.push_back(mk(1, 0, 2'b11, 0, 32'd0,   32'h0, 32'h0));
    ops.push_back(mk(1, 0, 2'b10, 0, 32'd128, 32'h0, 32'h0));
    ops.push_back(mk(0, 1, 2'b10, 0, 32'd136, 32'hFFFF_FFFF, 32'h0));
    chk = mk(1, 0, 2'b10, 0, 32'd8, 32'h0, 32'hDEAD_7777);
    foreach (ops[i]) begin
      do_req(ops[i], got, ge, lat, busy);
      model(ops[i], e_rd, e_err);
      checks++; if (ge !== 1'b1) begin failures++; $display("FAIL err_flag[%0d]: got %0b required 1", i, ge); end
      checks++; if (got !== 32'h0) begin failures++; $display("FAIL err_rdata[%0d]: got %h required 00000000", i, got); end
      do_req(chk, got, ge, lat, busy);
      model(chk, e_rd, e_err);
      checks++; if (got !== chk.exp_rd || ge !== 1'b0) begin failures++; $display("FAIL err_word8[%0d]: got %h/%0b required %h/0", i, got, ge, chk.exp_rd); end
    end
  endtask

  task automatic test_rw_both();
    op_t o;
    logic [31:0] got, e_rd;
    logic ge, e_err;
    int lat, busy;
    o = mk(1, 1, 2'b10, 0, 32'd8, 32'h1111_1111, 32'hDEAD_7777);
    do_req(o, got, ge, lat, busy);
    model(o, e_rd, e_err);
    checks++; if (got !== o.exp_rd || ge !== 1'b0) begin failures++; $display("FAIL rw_both_read: got %h/%0b required %h/0", got, ge, o.exp_rd); end
    o = mk(1, 0, 2'b10, 0, 32'd8, 32'h0, 32'hDEAD_7777);
    do_req(o, got, ge, lat, busy);
    model(o, e_rd, e_err);
    checks++; if (got !== o.exp_rd) begin failures++; $display("FAIL rw_both_unchanged: got %h required %h", got, o.exp_rd); end
  endtask

  task automatic test_reset_mid();
    op_t o;
    logic [31:0] got, e_rd;
    logic ge, e_err;
    int lat, busy, seen;
    o = mk(0, 1, 2'b10, 0, 32'd12, 32'hCAFE_F00D, 32'hx);
    @(negedge clk);
    drive_req(o);
    while (!req_ready) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_rdata = '0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_resp: got %0d pulses required 0", seen); end
    checks++; if (ReadData !== 32'h0 || req_ready !== 1'b1) begin failures++; $display("FAIL midreset_state: got %h/%0b required 00000000/1", ReadData, req_ready); end
    o = mk(1, 0, 2'b10, 0, 32'd12, 32'h0, 32'h0);
    do_req(o, got, ge, lat, busy);
    model(o, e_rd, e_err);
    checks++; if (got !== 32'h0 || ge !== 1'b0) begin failures++; $display("FAIL midreset_lw12: got %h/%0b required 00000000/0", got, ge); end
  endtask

  task automatic test_back_to_back();
    op_t a, b;
    logic [31:0] a_rd, e_rd;
    logic e_err;
    int k, a_k, ready_k, lat, extra;
    a = mk(1, 0, 2'b10, 0, 32'd4, 32'h0, 32'h0000_0054);
    b = mk(1, 0, 2'b10, 0, 32'd8, 32'h0, 32'hDEAD_7777);
    a_k = -1; ready_k = -1; a_rd = 'x;
    @(negedge clk);
    drive_req(a);
    while (!req_ready) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    drive_req(b);
    k = 0;
    while (k < 50) begin
      if (resp_valid) begin a_k = k; a_rd = ReadData; end
      if (req_ready) begin ready_k = k; break; end
      @(negedge clk);
      k++;
    end
    model(a, e_rd, e_err);
    checks++; if (a_k !== int'(WAIT_CYCLES) + 1 || a_rd !== a.exp_rd) begin failures++; $display("FAIL held_first: resp at %0d data %h required %0d/%h", a_k, a_rd, WAIT_CYCLES + 1, a.exp_rd); end
    checks++; if (ready_k !== int'(WAIT_CYCLES) + 1) begin failures++; $display("FAIL held_ready: ready at %0d required %0d", ready_k, WAIT_CYCLES + 1); end
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    lat = 0;
    while (!resp_valid && lat < 50) begin @(negedge clk); lat++; end
    model(b, e_rd, e_err);
    checks++; if (lat !== int'(WAIT_CYCLES) + 1 || ReadData !== b.exp_rd) begin failures++; $display("FAIL held_second: lat %0d data %h required %0d/%h", lat, ReadData, WAIT_CYCLES + 1, b.exp_rd); end
    extra = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (resp_valid) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL held_once: got %0d extra responses required 0", extra); end
  endtask

  task automatic test_random();
    op_t o;
    logic [31:0] got, e_rd;
    logic ge, e_err;
    int lat, busy;
    for (int i = 0; i < 60; i++) begin
      o.rd  = 1'($urandom_range(0, 1));
      o.wr  = o.rd ? 1'($urandom_range(0, 1)) : 1'b1;
      o.sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      o.uns = 1'($urandom_range(0, 1));
      o.a   = 32'($urandom_range(0, 4*DEPTH + 15));
      if ($urandom_range(0, 9) == 0) o.a |= 32'h1000_0000;
      o.wd  = $urandom;
      o.exp_rd = 'x;
      do_req(o, got, ge, lat, busy);
      model(o, e_rd, e_err);
      checks++; if (got !== e_rd) begin failures++; $display("FAIL rand_rdata[%0d] a=%h sz=%0d rd=%0b: got %h required %h", i, o.a, o.sz, o.rd, got, e_rd); end
      checks++; if (ge !== e_err) begin failures++; $display("FAIL rand_err[%0d] a=%h sz=%0d: got %0b required %0b", i, o.a, o.sz, ge, e_err); end
      checks++; if (lat !== int'(WAIT_CYCLES) + 1 || busy !== 0) begin failures++; $display("FAIL rand_timing[%0d]: lat %0d busy %0d required %0d/0", i, lat, busy, WAIT_CYCLES + 1); end
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    drive_idle();
    for (int i = 0; i < int'(4*DEPTH); i++) ref_bytes[i] = 8'h00;
    ref_bytes[4] = 8'h54;
    ref_bytes[8] = 8'h0B;
    ref_rdata = '0;
    test_reset();
    test_timing();
    test_sized();
    test_errors();
    test_rw_both();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
